// File: rtl/weight_fetch_ctrl.sv
// weight_fetch_ctrl
// Fetches a run of bytes from a fixed-latency memory starting at a base
// address and streams them out through a small FIFO with valid/ready.
// Requests are credit-limited so every outstanding response is guaranteed
// a FIFO slot.
//
// Ports
//   clk, rst_n             clock, async active-low reset
//   start                  one-cycle job launch (accepted only when idle)
//   base_addr, num_words   job parameters, captured on accepted start
//   busy, done             job in progress / one-cycle completion pulse
//   req_valid, req_addr    memory read request
//   resp_valid, resp_data  memory read response (one cycle after request)
//   out_valid, out_data,
//   out_last, out_ready    output byte stream
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | waiting for start
// S_FETCH | issuing reads while credit allows, streaming out
// S_DRAIN | all reads issued, emptying FIFO until the last byte pops
// S_FIN   | one-cycle done pulse, then back to idle

module weight_fetch_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] num_words,
  output logic             busy,
  output logic             done,
  output logic             req_valid,
  output logic [31:0]      req_addr,
  input  logic             resp_valid,
  input  logic [7:0]       resp_data,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_last,
  input  logic             out_ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W:0] DEPTH_L = (OCC_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [31:0]      r_base;
  logic [CNT_W-1:0] r_num;
  logic [CNT_W-1:0] r_issued;
  logic [CNT_W-1:0] r_popped;
  logic [OCC_W-1:0] r_inflight;
  logic [OCC_W-1:0] r_count;
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [7:0]       r_mem [FIFO_DEPTH];

  logic             w_accept;
  logic [OCC_W:0]   w_sum;
  logic             w_req;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_last;

  assign w_accept = (r_state == S_IDLE) && start;
  // Outstanding reads are counted against FIFO space so a response can
  // always be stored; there is no backpressure on the response side.
  assign w_sum    = {1'b0, r_count} + {1'b0, r_inflight};
  assign w_req    = (r_state == S_FETCH) && (r_issued < r_num) && (w_sum < DEPTH_L);
  // A response with nothing outstanding (e.g. left over from before a
  // reset) is dropped.
  assign w_push   = resp_valid && (r_inflight != '0);
  assign w_empty  = (r_count == '0);
  assign w_pop    = !w_empty && out_ready;
  assign w_last   = !w_empty && (r_popped == (r_num - CNT_W'(1)));

  assign req_valid = w_req;
  assign req_addr  = r_base + 32'(r_issued);
  assign out_valid = !w_empty;
  assign out_data  = w_empty ? 8'h00 : r_mem[r_rd];
  assign out_last  = w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (num_words == '0) ? S_FIN : S_FETCH;
        end
      end
      S_FETCH: begin
        busy = 1'b1;
        if (r_issued == r_num) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (w_pop && w_last) begin
          w_next = S_FIN;
        end
      end
      S_FIN: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base   <= '0;
      r_num    <= '0;
      r_issued <= '0;
      r_popped <= '0;
    end else begin
      if (w_accept) begin
        r_base   <= base_addr;
        r_num    <= num_words;
        r_issued <= '0;
        r_popped <= '0;
      end else begin
        if (w_req) begin
          r_issued <= r_issued + CNT_W'(1);
        end
        if (w_pop) begin
          r_popped <= r_popped + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= '0;
    end else begin
      case ({w_req, w_push})
        2'b10:   r_inflight <= r_inflight + OCC_W'(1);
        2'b01:   r_inflight <= r_inflight - OCC_W'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + OCC_W'(1);
        2'b01:   r_count <= r_count - OCC_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: out_data is forced to zero while empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= resp_data;
    end
  end

endmodule

// File: doc/weight_fetch_ctrl.md
WEIGHT_FETCH_CTRL -- requirements
Module: weight_fetch_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, output-buffer entries (power of two, >=2).
REQ-002 SHALL have parameter CNT_W, default 16, width of the word-count input and internal counters.
REQ-003 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle pulse launching a fetch job.
REQ-006 SHALL have port base_addr  input  32  first byte address; sampled on accepted start.
REQ-007 SHALL have port num_words  input  CNT_W  bytes to fetch; sampled on accepted start.
REQ-008 SHALL have port busy  output  1  high from accepted start until done pulse inclusive.
REQ-009 SHALL have port done  output  1  one-cycle job-complete pulse.
REQ-010 SHALL have port req_valid  output  1  memory read request.
REQ-011 SHALL have port req_addr  output  32  memory read address.
REQ-012 SHALL have port resp_valid  input  1  memory response strobe, one cycle after req_valid, no backpressure.
REQ-013 SHALL have port resp_data  input  8  memory response byte.
REQ-014 SHALL have port out_valid  output  1  stream byte available.
REQ-015 SHALL have port out_data  output  8  stream byte.
REQ-016 SHALL have port out_last  output  1  marks final byte of job; valid with out_valid.
REQ-017 SHALL have port out_ready  input  1  downstream accept.

Function
REQ-018 SHALL implement states IDLE, FETCH, DRAIN, FIN.
REQ-019 SHALL accept start only in IDLE; start in any other state SHALL be ignored.
REQ-020 On accepted start with num_words>0 SHALL latch base_addr/num_words and enter FETCH next cycle.
REQ-021 On accepted start with num_words==0 SHALL enter FIN, issue no requests, emit no stream bytes.
REQ-022 In FETCH SHALL assert req_valid iff issued<num_words and (fifo_count+inflight)<FIFO_DEPTH.
REQ-023 req_addr SHALL equal base_addr+issued, modulo 2^32 (wrap, no error).
REQ-024 inflight SHALL increment on req_valid, decrement on resp_valid, both same cycle nets zero.
REQ-025 Each resp_valid with inflight>0 SHALL push resp_data into the FIFO in response order.
REQ-026 resp_valid with inflight==0 SHALL be ignored (no push, no counter change).
REQ-027 Credit rule of REQ-022 SHALL guarantee no push to a full FIFO; overflow SHALL be unreachable.
REQ-028 FIFO pop and push in the same cycle SHALL be supported at full and at empty (push to empty visible next cycle).
REQ-029 out_valid SHALL equal FIFO not-empty; out_data SHALL be FIFO head; pop on out_valid&out_ready.
REQ-030 out_valid/out_data SHALL hold stable while out_valid&!out_ready.
REQ-031 out_last SHALL be high exactly when head is byte index num_words-1 of the job.
REQ-032 FETCH->DRAIN when issued==num_words; DRAIN->FIN on out_valid&out_ready&out_last.
REQ-033 FIN SHALL assert done for one cycle, then return to IDLE.
REQ-034 Peak throughput SHALL be one byte per cycle with out_ready held high; first request one cycle after start, first out_valid two cycles after first request.

Reset
REQ-035 rst_n low SHALL asynchronously force IDLE, req_valid=0, req_addr=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0, all counters and FIFO pointers 0.
REQ-036 Reset mid-job SHALL abandon the job; a response arriving after rst_n release SHALL be dropped per REQ-026.

Verification
REQ-037 base_addr=0x10, num_words=4, mem[0x10..0x13]=A1..A4, out_ready=1 -> req_addr 0x10..0x13 on consecutive cycles, out A1..A4, out_last on A4, done next cycle.
REQ-038 num_words=10, out_ready=0 for 20 cycles -> exactly 4 requests issued, req_valid then low, out_valid held with byte 0; on release all 10 bytes in order, no loss.
REQ-039 num_words=0 -> no req_valid, no out_valid, busy high 1-2 cycles, done pulse.
REQ-040 base_addr=0xFFFFFFFE, num_words=3 -> req_addr FFFFFFFE, FFFFFFFF, 00000000.
REQ-041 start pulsed during FETCH with different base_addr -> ignored, original job completes unchanged.
REQ-042 rst_n low while inflight=1, released, spurious resp_valid injected -> out_valid stays 0, IDLE retained, new job runs correctly.
